color_cache_filler: RTL and testbench

Writer side of the CacheColor block: on command, streams NWORDS 16-bit colour halfwords from synchronous data memory into CacheColor addresses 0..NWORDS-1. Drives CacheColor's SH/WE/di/address inputs directly. Also forwards shift requests from the pixel pipeline as single SH pulses, never overlapping a write. Sits between the memory port and CacheColor in the colour datapath.

---
 rtl/color_cache_filler_if.sv | 23 ++
 rtl/color_cache_filler.sv | 94 +++++++++
 tb/tb_color_cache_filler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/color_cache_filler_if.sv
// color_cache_filler_if: command, memory-port and CacheColor-port signals of the colour cache filler.
interface color_cache_filler_if;
    logic        start;
    logic [31:0] base_addr;
    logic        shift_req;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        cache_sh;
    logic        cache_we;
    logic [15:0] cache_di;
    logic [2:0]  cache_addr;
    logic        busy;
    logic        done;
    modport master (
        output start, base_addr, shift_req, mem_rdata,
        input  mem_rd, mem_addr, cache_sh, cache_we, cache_di, cache_addr, busy, done
    );
    modport slave (
        input  start, base_addr, shift_req, mem_rdata,
        output mem_rd, mem_addr, cache_sh, cache_we, cache_di, cache_addr, busy, done
    );
endinterface

// File: rtl/color_cache_filler.sv
// color_cache_filler: streams NWORDS halfwords from memory into CacheColor and
// forwards shift requests as single SH pulses that never overlap a write.
module color_cache_filler #(
    parameter int NWORDS      = 6,
    parameter int ADDR_STRIDE = 2
) (
    input logic clk,
    input logic rst,
    color_cache_filler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, DRAIN, SHIFT, DONE} state_t;
    localparam logic [31:0] STRIDE = ADDR_STRIDE;
    state_t      state;
    logic [31:0] base;
    logic [3:0]  idx;
    logic [2:0]  widx;
    logic        rv;
    logic        pend;
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            base           <= '0;
            idx            <= '0;
            widx           <= '0;
            rv             <= 1'b0;
            pend           <= 1'b0;
            bus.mem_rd     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.cache_sh   <= 1'b0;
            bus.cache_we   <= 1'b0;
            bus.cache_di   <= '0;
            bus.cache_addr <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            // rv marks the cycle in which mem_rdata answers a read, so writes trail reads by two cycles
            rv           <= bus.mem_rd;
            bus.cache_we <= rv;
            if (rv) begin
                bus.cache_di   <= bus.mem_rdata;
                bus.cache_addr <= widx;
                widx           <= widx + 3'd1;
            end
            bus.mem_rd   <= 1'b0;
            bus.cache_sh <= 1'b0;
            bus.done     <= 1'b0;
            pend         <= pend | bus.shift_req;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= READ;
                        base     <= bus.base_addr;
                        idx      <= '0;
                        widx     <= '0;
                        bus.busy <= 1'b1;
                    end else if (pend || bus.shift_req) begin
                        state        <= SHIFT;
                        bus.cache_sh <= 1'b1;
                        pend         <= 1'b0;
                    end
                end
                READ: begin
                    bus.mem_rd   <= 1'b1;
                    bus.mem_addr <= base + 32'(idx) * STRIDE;
                    idx          <= idx + 4'd1;
                    if (idx == 4'(NWORDS - 1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.mem_rd && !rv) begin
                        if (pend || bus.shift_req) begin
                            state        <= SHIFT;
                            bus.cache_sh <= 1'b1;
                            pend         <= 1'b0;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    // busy still high means this pulse closes a fill
                    state <= bus.busy ? DONE : IDLE;
                    if (bus.busy) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_color_cache_filler.sv
// tb_color_cache_filler: randomized scoreboard bench; expected events are queued at issue time
// with their absolute cycle, and a negedge monitor pops them as the DUT presents outputs.
module tb_color_cache_filler;
    localparam int N      = 6;
    localparam int STRIDE = 2;
    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [15:0] d;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t q_rd[$], q_wr[$], q_sh[$], q_dn[$];
    logic [15:0] pre [logic [31:0]];
    color_cache_filler_if bus ();
    color_cache_filler #(.NWORDS(N), .ADDR_STRIDE(STRIDE)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return pre.exists(a) ? pre[a] : (a[15:0] * 16'd40503) ^ a[31:16];
    endfunction
    always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem_word(bus.mem_addr);
    function automatic exp_t mk(input int c, input logic [31:0] a, input logic [15:0] d);
        exp_t e;
        e.cyc = c;
        e.a   = a;
        e.d   = d;
        return e;
    endfunction
    task automatic chk(input string n, input logic [47:0] got, input logic [47:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, want, cyc);
    endtask
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic purge(ref exp_t q[$], input int lim);
        exp_t t[$];
        foreach (q[i]) if (q[i].cyc < lim) t.push_back(q[i]);
        q = t;
    endtask
    task automatic zeros(input string tag);
        chk({tag, "_mem_rd"}, 48'(bus.mem_rd), 48'(0));
        chk({tag, "_mem_addr"}, 48'(bus.mem_addr), 48'(0));
        chk({tag, "_cache_sh"}, 48'(bus.cache_sh), 48'(0));
        chk({tag, "_cache_we"}, 48'(bus.cache_we), 48'(0));
        chk({tag, "_cache_di"}, 48'(bus.cache_di), 48'(0));
        chk({tag, "_cache_addr"}, 48'(bus.cache_addr), 48'(0));
        chk({tag, "_busy"}, 48'(bus.busy), 48'(0));
        chk({tag, "_done"}, 48'(bus.done), 48'(0));
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_rd) begin
            if (q_rd.size() == 0) chk("rd_unexpected", 48'(bus.mem_addr), 48'hDEAD);
            else begin
                e = q_rd.pop_front();
                chk("rd_cycle", 48'(cyc), 48'(e.cyc));
                chk("rd_addr", 48'(bus.mem_addr), 48'(e.a));
            end
        end
        if (bus.cache_we) begin
            if (q_wr.size() == 0) chk("wr_unexpected", 48'(bus.cache_addr), 48'hDEAD);
            else begin
                e = q_wr.pop_front();
                chk("wr_cycle", 48'(cyc), 48'(e.cyc));
                chk("wr_addr", 48'(bus.cache_addr), 48'(e.a));
                chk("wr_data", 48'(bus.cache_di), 48'(e.d));
            end
        end
        if (bus.cache_sh) begin
            if (q_sh.size() == 0) chk("sh_unexpected", 48'(bus.cache_sh), 48'h0);
            else begin
                e = q_sh.pop_front();
                chk("sh_cycle", 48'(cyc), 48'(e.cyc));
                chk("sh_busy", 48'(bus.busy), 48'(e.d));
                chk("sh_we_overlap", 48'(bus.cache_we), 48'(0));
            end
        end
        if (bus.done) begin
            if (q_dn.size() == 0) chk("done_unexpected", 48'(bus.done), 48'h0);
            else begin
                e = q_dn.pop_front();
                chk("done_cycle", 48'(cyc), 48'(e.cyc));
                chk("done_busy", 48'(bus.busy), 48'(0));
            end
        end
    end
    // m[t] pulses shift_req during fill cycle t; restart_at/reset_at name the cycle of a stray start or rst
    task automatic fill(input logic [31:0] b, input logic [15:0] m, input int restart_at, input int reset_at);
        int c0;
        bus.start     = 1'b1;
        bus.base_addr = b;
        step();
        bus.start     = 1'b0;
        bus.base_addr = $urandom;
        c0 = cyc;
        for (int k = 0; k < N; k++) begin
            q_rd.push_back(mk(c0 + 1 + k, b + 32'(k * STRIDE), 16'h0));
            q_wr.push_back(mk(c0 + 3 + k, 32'(k), mem_word(b + 32'(k * STRIDE))));
        end
        if (|m[N:0]) begin
            q_sh.push_back(mk(c0 + N + 3, 32'h0, 16'h1));
            q_dn.push_back(mk(c0 + N + 4, 32'h0, 16'h0));
        end else q_dn.push_back(mk(c0 + N + 3, 32'h0, 16'h0));
        for (int t = 0; t <= N + 6; t++) begin
            bus.shift_req = (t <= N) ? m[t] : 1'b0;
            bus.start     = (t == restart_at);
            if (t == restart_at) bus.base_addr = 32'h200;
            if (t == reset_at) begin
                rst = 1'b1;
                purge(q_rd, c0 + t + 1);
                purge(q_wr, c0 + t + 1);
                purge(q_sh, c0 + t + 1);
                purge(q_dn, c0 + t + 1);
            end
            step();
            if (t == reset_at) begin
                rst = 1'b0;
                @(negedge clk);
                zeros("midfill_reset");
            end
        end
        bus.shift_req = 1'b0;
        bus.start     = 1'b0;
    endtask
    task automatic idle_shift();
        bus.shift_req = 1'b1;
        step();
        q_sh.push_back(mk(cyc, 32'h0, 16'h0));
        bus.shift_req = 1'b0;
        repeat (3) step();
    endtask
    initial begin
        logic [15:0] basic [6] = '{16'hFAFD, 16'hAABB, 16'h9918, 16'h7744, 16'h33CC, 16'h1155};
        logic [15:0] m;
        foreach (basic[k]) pre[32'h100 + 32'(k * STRIDE)] = basic[k];
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.shift_req = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        zeros("reset");
        step();
        fill(32'h100, 16'h0, -1, -1);
        idle_shift();
        fill(32'h40, 16'h0025, -1, -1);
        fill(32'h100, 16'h0, 4, -1);
        fill(32'h300, 16'h0, -1, 5);
        fill(32'h100, 16'h0, -1, -1);
        fill(32'hFFFF_FFFC, 16'h0, -1, -1);
        for (int r = 0; r < 12; r++) begin
            m = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
            fill($urandom & 32'hFFFF_FFFE, m, -1, -1);
            if ($urandom_range(0, 1) == 1) idle_shift();
        end
        repeat (4) step();
        chk("left_rd", 48'(q_rd.size()), 48'(0));
        chk("left_wr", 48'(q_wr.size()), 48'(0));
        chk("left_sh", 48'(q_sh.size()), 48'(0));
        chk("left_done", 48'(q_dn.size()), 48'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
